fp_addsub_dispatch: RTL and testbench

FP_ADDSUB_DISPATCH -- requirements
Module: fp_addsub_dispatch

---
 rtl/fp_addsub_dispatch.sv | 182 ++++++++++++++++++
 tb/tb_fp_addsub_dispatch.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_dispatch.sv
// fp_addsub_dispatch: buffers FP32 add/sub operand sets in a small FIFO and
// feeds them one at a time to an external add/sub core. Each result is held
// in a result register until consumed. A request the core never answers is
// abandoned after TIMEOUT wait cycles and replaced by a quiet NaN flagged
// with out_err.
module fp_addsub_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 63
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_op,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic                     out_err,
  output logic                     core_start,
  output logic                     core_op,
  output logic [31:0]              core_a,
  output logic [31:0]              core_b,
  input  logic                     core_busy,
  input  logic                     core_ready,
  input  logic [31:0]              core_data,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [PW-1:0] FULL_COUNT = PW'(DEPTH);
  localparam logic [TW-1:0] LAST_WAIT  = TW'(TIMEOUT - 1);
  localparam logic [31:0]   QNAN       = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [64:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  logic [TW-1:0] wait_cnt;
  logic          capture_core;
  logic          capture_timeout;

  // The handshake relies only on core_ready and the timeout; the core's busy
  // flag carries no extra information for this dispatcher.
  logic unused_core_busy;
  assign unused_core_busy = core_busy;

  assign in_ready = (pending != FULL_COUNT);
  assign push     = in_valid & in_ready;

  // FIFO storage; entries need no reset because pending gates every read.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {in_op, in_a, in_b};
    end
  end

  // Pointers wrap naturally at DEPTH (a power of two); occupancy holds when
  // a push and a pop land on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pending <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   pending <= pending + PW'(1);
        2'b01:   pending <= pending - PW'(1);
        default: pending <= pending;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode: only one request may be outstanding, and
  // a new one is issued only once the previous result has been consumed.
  always_comb begin
    state_nxt       = state;
    pop             = 1'b0;
    core_start      = 1'b0;
    capture_core    = 1'b0;
    capture_timeout = 1'b0;
    case (state)
      IDLE: begin
        if ((pending != '0) && !out_valid) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        core_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (core_ready) begin
          capture_core = 1'b1;
          state_nxt    = IDLE;
        end else if (wait_cnt == LAST_WAIT) begin
          capture_timeout = 1'b1;
          state_nxt       = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Wait counter: cleared while issuing so it starts at zero in WAIT, and
  // counts every WAIT cycle in which the core has not answered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if ((state == WAIT) && !core_ready) begin
      wait_cnt <= wait_cnt + TW'(1);
    end
  end

  // Operand register: loaded only on a pop, so the core sees stable operands
  // through the whole request and the last values persist while idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      core_op <= 1'b0;
      core_a  <= '0;
      core_b  <= '0;
    end else if (pop) begin
      {core_op, core_a, core_b} <= fifo_mem[rd_ptr];
    end
  end

  // Result register: filled by the core or by the timeout, held until the
  // consumer takes it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (capture_core) begin
      out_valid <= 1'b1;
      out_data  <= core_data;
      out_err   <= 1'b0;
    end else if (capture_timeout) begin
      out_valid <= 1'b1;
      out_data  <= QNAN;
      out_err   <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_addsub_dispatch.sv
// Testbench for fp_addsub_dispatch: a behavioural FP32 core model answers
// requests after a programmable delay; expected results are queued as
// operand sets are pushed and compared as the consumer takes results.
module tb_fp_addsub_dispatch;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 63;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_op;
  logic [31:0]            in_a;
  logic [31:0]            in_b;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_data;
  logic                   out_err;
  logic                   core_start;
  logic                   core_op;
  logic [31:0]            core_a;
  logic [31:0]            core_b;
  logic                   core_busy  = 1'b0;
  logic                   core_ready = 1'b0;
  logic [31:0]            core_data  = 32'h0;
  logic [$clog2(DEPTH):0] pending;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [32:0] sb_q [$];
  logic [32:0] obs_q [$];
  int          obs_rd = 0;

  int          core_delay   = 8;
  int          drop_idx     = -1;
  logic        inject_ready = 1'b0;
  int          start_cnt    = 0;
  int          rsp_cnt      = 0;
  logic        cap_op       = 1'b0;
  logic [31:0] cap_a        = 32'h0;
  logic [31:0] cap_b        = 32'h0;
  logic [31:0] rsp_data     = 32'h0;
  bit          stable_ok    = 1'b1;

  fp_addsub_dispatch #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err),
    .core_start (core_start),
    .core_op    (core_op),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_busy  (core_busy),
    .core_ready (core_ready),
    .core_data  (core_data),
    .pending    (pending)
  );

  always #5 clock = ~clock;

  // Behaviour of the external core: known FP32 sums for the directed cases,
  // a plain integer mix otherwise so every streamed result is distinct.
  function automatic logic [31:0] coreModel(input logic op, input logic [31:0] a, input logic [31:0] b);
    case ({op, a, b})
      {1'b0, 32'h3F800000, 32'h40000000}: return 32'h40400000;
      {1'b1, 32'h3F800000, 32'h3F800000}: return 32'h00000000;
      {1'b0, 32'h40000000, 32'h40000000}: return 32'h40800000;
      {1'b1, 32'h40400000, 32'h3F800000}: return 32'h40000000;
      default:                            return op ? (a - b) : (a + b);
    endcase
  endfunction

  // Core model: accepts starts, answers after core_delay cycles unless the
  // start is the one chosen to be dropped, and watches operand stability.
  always @(negedge clock) begin
    core_ready = 1'b0;
    if (reset) begin
      rsp_cnt = 0;
    end else begin
      if (inject_ready) begin
        core_ready = 1'b1;
        core_data  = 32'h12345678;
      end
      if (rsp_cnt > 0) begin
        if (core_op !== cap_op || core_a !== cap_a || core_b !== cap_b) stable_ok = 1'b0;
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          core_ready = 1'b1;
          core_data  = rsp_data;
        end
      end
      if (core_start) begin
        if (start_cnt != drop_idx) begin
          rsp_cnt  = core_delay;
          cap_op   = core_op;
          cap_a    = core_a;
          cap_b    = core_b;
          rsp_data = coreModel(core_op, core_a, core_b);
        end
        start_cnt++;
      end
    end
    core_busy = (rsp_cnt > 0);
  end

  // Consumer-side monitor: records every result taken by the consumer.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) obs_q.push_back({out_err, out_data});
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [32:0] observed, input logic [32:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic op, input logic [31:0] a, input logic [31:0] b,
                               input logic [32:0] exp, input bit want);
    int w = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    while (!in_ready && w < 200) begin
      step(1);
      w++;
    end
    if (!in_ready) begin
      checkOutput("push_accept", 33'(in_ready), 33'(1));
    end else begin
      step(1);
      if (want) sb_q.push_back(exp);
    end
    in_valid = 1'b0;
  endtask

  task automatic waitResult(input string tag);
    int w = 0;
    logic [32:0] exp;
    while (obs_q.size() <= obs_rd && w < 500) begin
      step(1);
      w++;
    end
    if (obs_q.size() <= obs_rd) begin
      checkOutput({tag, "_count"}, 33'(obs_q.size()), 33'(obs_rd + 1));
    end else begin
      exp = sb_q.pop_front();
      checkOutput({tag, "_err"},  {32'b0, obs_q[obs_rd][32]},  {32'b0, exp[32]});
      checkOutput({tag, "_data"}, {1'b0, obs_q[obs_rd][31:0]}, {1'b0, exp[31:0]});
      obs_rd++;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s0;
    int lat;
    in_valid  = 1'b0;
    in_op     = 1'b0;
    in_a      = 32'h0;
    in_b      = 32'h0;
    out_ready = 1'b0;
    reset     = 1'b1;
    step(3);
    reset = 1'b0;
    #1;
    $display("[TB] reset values");
    checkOutput("rst_in_ready",   33'(in_ready),   33'(1));
    checkOutput("rst_pending",    33'(pending),    33'(0));
    checkOutput("rst_out_valid",  33'(out_valid),  33'(0));
    checkOutput("rst_out_err",    33'(out_err),    33'(0));
    checkOutput("rst_out_data",   33'(out_data),   33'(0));
    checkOutput("rst_core_start", 33'(core_start), 33'(0));
    checkOutput("rst_core_op",    33'(core_op),    33'(0));
    checkOutput("rst_core_a",     33'(core_a),     33'(0));
    checkOutput("rst_core_b",     33'(core_b),     33'(0));
    step(1);

    $display("[TB] single add");
    out_ready = 1'b1;
    s0 = start_cnt;
    applyStimulus(1'b0, 32'h3F800000, 32'h40000000, {1'b0, 32'h40400000}, 1'b1);
    checkOutput("issue_not_early", 33'(core_start), 33'(0));
    step(1);
    checkOutput("issue_start", 33'(core_start), 33'(1));
    lat = 0;
    while (!out_valid && lat < 100) begin
      step(1);
      lat++;
    end
    checkOutput("add_latency", 33'(lat), 33'(core_delay + 1));
    waitResult("single_add");
    checkOutput("single_add_stable", 33'(stable_ok), 33'(1));
    checkOutput("single_add_starts", 33'(start_cnt - s0), 33'(1));

    $display("[TB] back-pressure");
    out_ready = 1'b0;
    s0 = start_cnt;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i[0], 32'h100 + 32'(i), 32'h10 + 32'(i),
                    {1'b0, coreModel(i[0], 32'h100 + 32'(i), 32'h10 + 32'(i))}, 1'b1);
    end
    checkOutput("bp_in_ready", 33'(in_ready), 33'(0));
    checkOutput("bp_pending",  33'(pending),  33'(4));
    in_valid = 1'b1;
    in_op    = 1'b1;
    in_a     = 32'hDEADBEEF;
    in_b     = 32'h0BADF00D;
    step(4);
    in_valid = 1'b0;
    checkOutput("bp_pending_hold", 33'(pending), 33'(4));
    step(12);
    checkOutput("bp_held_valid", 33'(out_valid), 33'(1));
    checkOutput("bp_held_data",  {1'b0, out_data}, {1'b0, sb_q[0][31:0]});
    step(3);
    checkOutput("bp_held_data_again", {1'b0, out_data}, {1'b0, sb_q[0][31:0]});
    checkOutput("bp_single_start", 33'(start_cnt - s0), 33'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) waitResult("bp_result");
    step(2);
    checkOutput("bp_pending_drained", 33'(pending), 33'(0));

    $display("[TB] ordering");
    applyStimulus(1'b1, 32'h3F800000, 32'h3F800000, {1'b0, 32'h00000000}, 1'b1);
    applyStimulus(1'b0, 32'h40000000, 32'h40000000, {1'b0, 32'h40800000}, 1'b1);
    applyStimulus(1'b1, 32'h40400000, 32'h3F800000, {1'b0, 32'h40000000}, 1'b1);
    for (int i = 0; i < 3; i++) waitResult("order");

    $display("[TB] timeout");
    step(2);
    drop_idx = start_cnt;
    applyStimulus(1'b1, 32'h11111111, 32'h22222222, {1'b1, 32'h7FC00000}, 1'b1);
    applyStimulus(1'b0, 32'h40000000, 32'h40000000, {1'b0, 32'h40800000}, 1'b1);
    lat = 0;
    while (!core_start && lat < 10) begin
      step(1);
      lat++;
    end
    checkOutput("to_issue", 33'(core_start), 33'(1));
    lat = 0;
    while (!out_valid && lat < TIMEOUT + 20) begin
      step(1);
      lat++;
    end
    // TIMEOUT wait cycles pass, then the NaN appears one cycle later.
    checkOutput("to_latency", 33'(lat), 33'(TIMEOUT + 1));
    waitResult("to_result");
    waitResult("to_next");

    $display("[TB] reset during wait");
    step(2);
    drop_idx = start_cnt;
    applyStimulus(1'b0, 32'h55555555, 32'h00000001, 33'h0, 1'b0);
    lat = 0;
    while (!core_start && lat < 10) begin
      step(1);
      lat++;
    end
    step(3);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
    inject_ready = 1'b1;
    step(1);
    inject_ready = 1'b0;
    step(4);
    checkOutput("mid_rst_out_valid", 33'(out_valid), 33'(0));
    checkOutput("mid_rst_pending",   33'(pending),   33'(0));
    checkOutput("mid_rst_out_data",  33'(out_data),  33'(0));
    checkOutput("mid_rst_out_err",   33'(out_err),   33'(0));

    $display("[TB] wrap-around stream");
    core_delay = 2;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(i[0], 32'h1000 + 32'(3 * i), 32'h20 + 32'(i),
                    {1'b0, coreModel(i[0], 32'h1000 + 32'(3 * i), 32'h20 + 32'(i))}, 1'b1);
    end
    for (int i = 0; i < 20; i++) waitResult("stream");
    step(3);
    checkOutput("stream_pending", 33'(pending), 33'(0));
    checkOutput("no_extra_results", 33'(obs_q.size()), 33'(obs_rd));
    checkOutput("operands_stable", 33'(stable_ok), 33'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
